// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - eFPGA configuration stream loader (optional checksum: FPGA_CFG_LOADER_CHECKSUM_EN)
module fpga_cfg_loader #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] SYNC_WORD = 32'hFAB0_FAB1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [31:0]       frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              cfg_active,
    output logic              cfg_done,
    output logic              cfg_error
);

    typedef enum logic [2:0] {
        S_HUNT  = 3'd0,
        S_CMD   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_DONE  = 4'hF;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    // Only the three previous bytes are kept; the incoming byte completes the 32-bit window.
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       remain_q, remain_d;
    logic [ADDR_W-1:0] frame_addr_q, frame_addr_d;
    logic [31:0]       frame_data_q, frame_data_d;
    logic              frame_valid_q, frame_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
    logic [31:0]       checksum_q, checksum_d;
`endif

    logic              accept;
    logic              word_done;
    logic [31:0]       word;

    // Next-state decode, word assembly and frame sequencing.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        addr_d        = addr_q;
        remain_d      = remain_q;
        frame_addr_d  = frame_addr_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif
        accept    = in_valid && in_ready_q;
        word      = {shift_q, in_data};
        word_done = accept && (cnt_q == 2'd3);

        if (accept) begin
            shift_d = word[23:0];
            cnt_d   = cnt_q + 2'd1;
        end

        case (state_q)
            S_HUNT: begin
                // Byte alignment is unknown while hunting, so the counter stays parked at 0.
                cnt_d = 2'd0;
                if (accept && (word == SYNC_WORD)) begin
                    state_d    = S_CMD;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
                    checksum_d = 32'd0;
`endif
                end
            end
            S_CMD: begin
                if (word_done) begin
                    case (word[31:28])
                        OP_NOP: state_d = S_CMD;
                        OP_WRITE: begin
                            addr_d   = word[ADDR_W-1:0];
                            remain_d = word[27:16];
                            state_d  = S_DATA;
                        end
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
                        OP_DONE: state_d = S_CHECK;
`else
                        OP_DONE: state_d = S_DONE;
`endif
                        default: state_d = S_ERROR;
                    endcase
                end
            end
            S_DATA: begin
                if (word_done) begin
                    frame_data_d  = word;
                    frame_addr_d  = addr_q;
                    frame_valid_d = 1'b1;
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: begin
                if (frame_valid_q && frame_ready) begin
                    frame_valid_d = 1'b0;
                    addr_d        = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
                    checksum_d    = checksum_q + frame_data_q;
`endif
                    if (remain_q == 12'd0) begin
                        state_d = S_CMD;
                    end else begin
                        remain_d = remain_q - 12'd1;
                        state_d  = S_DATA;
                    end
                end
            end
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (word_done) begin
                    state_d = (word == checksum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        // Byte intake pauses only while a frame is outstanding.
        in_ready_d = (state_d != S_WRITE);
        done_d     = done_q  || (state_d == S_DONE);
        error_d    = error_q || (state_d == S_ERROR);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= 2'd0;
            shift_q       <= 24'd0;
            addr_q        <= '0;
            remain_q      <= 12'd0;
            frame_addr_q  <= '0;
            frame_data_q  <= 32'd0;
            frame_valid_q <= 1'b0;
            in_ready_q    <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
            checksum_q    <= 32'd0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            addr_q        <= addr_d;
            remain_q      <= remain_d;
            frame_addr_q  <= frame_addr_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            in_ready_q    <= in_ready_d;
            done_q        <= done_d;
            error_q       <= error_d;
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
            checksum_q    <= checksum_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign frame_addr  = frame_addr_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign cfg_done    = done_q;
    assign cfg_error   = error_q;
    assign cfg_active  = (state_q == S_CMD) || (state_q == S_DATA) || (state_q == S_WRITE)
`ifdef FPGA_CFG_LOADER_CHECKSUM_EN
                         || (state_q == S_CHECK)
`endif
                         ;

endmodule
